// File: rtl/arb_sp_ram_pkg.sv
// Shared constants, types and helpers for the arbitrated single-port RAM.
package arb_sp_ram_pkg;

  // Reset value of every read-data register: the RISC-V NOP (addi x0,x0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One byte lane of a memory word.
  typedef logic [7:0] byte_lane_t;

  // Width needed to hold a port index; a single port still needs one bit.
  function automatic int port_idx_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/arb_sp_ram_rr_arbiter.sv
// Per-cycle arbiter for arb_sp_ram: one-hot grant, combinational from req_i.
// Build option: define RAM_ARB_RR_EN for round-robin arbitration with a
// registered priority pointer; otherwise fixed priority (lowest index wins).
module rr_arbiter
  import arb_sp_ram_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic                               clk,
  input  logic                               rstn_i,
  input  logic [NUM_PORTS-1:0]               req_i,
  output logic [NUM_PORTS-1:0]               gnt_o,
  output logic [port_idx_w(NUM_PORTS)-1:0]   gnt_idx_o
);

  localparam int PW = port_idx_w(NUM_PORTS);

`ifdef RAM_ARB_RR_EN

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] cand;
  logic          found;

  // Search from the pointer upward (wrapping); the first requester wins and
  // the pointer moves just past it. No request leaves the pointer alone.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    ptr_next  = ptr_reg;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PW'((int'(ptr_reg) + i) % NUM_PORTS);
      if (!found && req_i[cand]) begin
        found     = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o = cand;
        ptr_next  = PW'((int'(cand) + 1) % NUM_PORTS);
      end
    end
  end

  // Priority pointer register; every grant is a transfer since the grant
  // is only ever given to a requesting port.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

`else

  // Fixed priority has no state, so clock and reset are not needed here.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rstn_i;

  // Scan from the top down so the lowest requesting index is the last
  // assignment and therefore wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_i[PW'(i)]) begin
        gnt_o     = '0;
        gnt_o[PW'(i)] = 1'b1;
        gnt_idx_o = PW'(i);
      end
    end
  end

`endif

endmodule

// File: rtl/arb_sp_ram.sv
// Single-port on-chip RAM shared by NUM_PORTS requesters via req/gnt/rvalid.
// Grants are combinational, read data is registered one cycle after the
// grant and held per port until that port's next response.
// Build option: RAM_ARB_RR_EN selects round-robin arbitration (see rr_arbiter).
module arb_sp_ram
  import arb_sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTES  = 1024,
  parameter int NUM_PORTS  = 2
) (
  input  logic                               clk,
  input  logic                               rstn_i,
  input  logic [NUM_PORTS-1:0]               req_i,
  output logic [NUM_PORTS-1:0]               gnt_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    addr_i,
  input  logic [NUM_PORTS-1:0]               we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    wdata_i,
  output logic [NUM_PORTS-1:0]               rvalid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]    rdata_o,
  output logic [NUM_PORTS-1:0]               err_o
);

  localparam int BYTES_W = DATA_WIDTH / 8;
  localparam int OFF_W   = $clog2(BYTES_W);
  localparam int IDX_W   = ADDR_WIDTH - OFF_W;
  localparam int WORDS   = NUM_BYTES / BYTES_W;
  localparam int MEM_AW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW      = port_idx_w(NUM_PORTS);

  localparam logic [DATA_WIDTH-1:0] RDATA_RST = {{(DATA_WIDTH-7){1'b0}}, NOP_INSTR[6:0]};

  logic [NUM_PORTS-1:0]  gnt;
  logic [PW-1:0]         gnt_idx;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [BYTES_W-1:0]    sel_be;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [IDX_W-1:0]      sel_idx;
  logic [MEM_AW-1:0]     mem_idx;
  logic                  in_range;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_word;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .clk       (clk),
    .rstn_i    (rstn_i),
    .req_i     (req_i),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign gnt_o = gnt;
  assign xfer  = |(req_i & gnt);

  // Only one port is granted per cycle, so a single mux feeds the array.
  assign sel_addr  = addr_i [gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_we    = we_i   [gnt_idx];
  assign sel_be    = be_i   [gnt_idx*BYTES_W +: BYTES_W];
  assign sel_wdata = wdata_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

  // Byte-offset bits do not take part in word addressing.
  logic [OFF_W-1:0] unused_addr_off;
  assign unused_addr_off = sel_addr[OFF_W-1:0];

  assign sel_idx  = sel_addr[ADDR_WIDTH-1:OFF_W];
  assign mem_idx  = sel_idx[MEM_AW-1:0];
  assign in_range = (32'(sel_idx) < 32'(WORDS));

  // Out-of-range writes are dropped; the reset term keeps a write from
  // landing on the edge where reset is still asserted.
  assign wr_en = rstn_i && xfer && sel_we && in_range;

  // One narrow array per byte lane so each enable maps to its own write.
  for (genvar gi = 0; gi < BYTES_W; gi++) begin : g_lane
    byte_lane_t mem [WORDS];

    // Byte-lane write; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
      if (wr_en && sel_be[gi]) begin
        mem[mem_idx] <= sel_wdata[gi*8 +: 8];
      end
    end

    assign rd_word[gi*8 +: 8] = mem[mem_idx];
  end

  // Per-port response registers: rvalid pulses for one cycle, data and
  // error are held until this port's next transfer. rd_word is sampled
  // before the same-edge write, so a write returns the old word.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
    always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
        rvalid_o[gi]                        <= 1'b0;
        err_o[gi]                           <= 1'b0;
        rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] <= RDATA_RST;
      end else begin
        rvalid_o[gi] <= req_i[gi] & gnt[gi];
        if (req_i[gi] && gnt[gi]) begin
          rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] <= in_range ? rd_word : '0;
          err_o[gi]                           <= ~in_range;
        end
      end
    end
  end

endmodule

// File: tb/tb_arb_sp_ram.sv
// Directed bench for arb_sp_ram (default parameters, two ports).
// Expectations follow RAM_ARB_RR_EN when the bench is built with it.
module tb_arb_sp_ram;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NB = 1024;
  localparam int NP = 2;

  logic             clk = 1'b0;
  logic             rstn_i;
  logic [NP-1:0]    req_i, gnt_o, we_i, rvalid_o, err_o;
  logic [NP*AW-1:0] addr_i;
  logic [NP*4-1:0]  be_i;
  logic [NP*DW-1:0] wdata_i, rdata_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] exp_gnt;

  always #5 clk = ~clk;

  arb_sp_ram #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_BYTES  (NB),
    .NUM_PORTS  (NP)
  ) dut (
    .clk      (clk),
    .rstn_i   (rstn_i),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .be_i     (be_i),
    .wdata_i  (wdata_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic drive(input int p, input logic we, input logic [15:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    req_i[p]            = 1'b1;
    we_i[p]             = we;
    addr_i[p*AW +: AW]  = a;
    be_i[p*4 +: 4]      = be;
    wdata_i[p*DW +: DW] = d;
  endtask

  function automatic logic [31:0] rd(input int p);
    return rdata_o[p*DW +: DW];
  endfunction

  // Single-port transfer: entered just after a rising edge, returns just
  // after the response edge with all requests dropped.
  task automatic access(input string tag, input int p, input logic we,
                        input logic [15:0] a, input logic [3:0] be, input logic [31:0] d,
                        input bit chk, input logic [31:0] exp_d, input logic exp_e);
    req_i = '0;
    drive(p, we, a, be, d);
    #1;
    if (chk) check_eq({tag, ".gnt"}, 32'(gnt_o), 32'(1 << p));
    @(posedge clk); #1;
    req_i = '0;
    if (chk) begin
      check_eq({tag, ".rvalid"}, 32'(rvalid_o[p]), 32'd1);
      check_eq({tag, ".rdata"},  rd(p), exp_d);
      check_eq({tag, ".err"},    32'(err_o[p]), 32'(exp_e));
    end
  endtask

  initial begin
    rstn_i  = 1'b0;
    req_i   = '0;
    we_i    = '0;
    addr_i  = '0;
    be_i    = '0;
    wdata_i = '0;

    // Reset state with no requests.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rst.rvalid", 32'(rvalid_o), 32'd0);
    check_eq("rst.err",    32'(err_o),    32'd0);
    check_eq("rst.rdata0", rd(0), 32'h0000_0013);
    check_eq("rst.rdata1", rd(1), 32'h0000_0013);
    check_eq("rst.gnt",    32'(gnt_o),    32'd0);
    rstn_i = 1'b1;
    @(posedge clk); #1;

    // Establish zeroed words used below.
    access("clr00", 0, 1'b1, 16'h0000, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
    access("clr10", 0, 1'b1, 16'h0010, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
    access("clr20", 0, 1'b1, 16'h0020, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);

    // Byte-enabled write, then read from the other port.
    access("be.wr", 0, 1'b1, 16'h0010, 4'b0101, 32'hAABB_CCDD, 1'b1, 32'h0, 1'b0);
    access("be.rd", 1, 1'b0, 16'h0010, 4'h0, 32'h0, 1'b1, 32'h00BB_00DD, 1'b0);

    // Both ports requesting for six cycles.
    req_i = '0;
    drive(0, 1'b0, 16'h0010, 4'h0, 32'h0);
    drive(1, 1'b0, 16'h0010, 4'h0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      #1;
`ifdef RAM_ARB_RR_EN
      exp_gnt = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_gnt = 2'b01;
`endif
      check_eq($sformatf("arb.c%0d.gnt", c), 32'(gnt_o), 32'(exp_gnt));
      @(posedge clk); #1;
      check_eq($sformatf("arb.c%0d.rvalid", c), 32'(rvalid_o), 32'(exp_gnt));
    end
    req_i = '0;
    @(posedge clk); #1;

    // Read-after-write on back-to-back edges from different ports.
    drive(0, 1'b1, 16'h0020, 4'hF, 32'h1234_5678);
    #1;
    check_eq("raw.wr.gnt", 32'(gnt_o), 32'd1);
    @(posedge clk); #1;
    req_i = '0;
    drive(1, 1'b0, 16'h0020, 4'h0, 32'h0);
    #1;
    check_eq("raw.rd.gnt",    32'(gnt_o),    32'd2);
    check_eq("raw.wr.rvalid", 32'(rvalid_o), 32'd1);
    check_eq("raw.wr.rdata",  rd(0),         32'h0);
    @(posedge clk); #1;
    req_i = '0;
    check_eq("raw.rd.rvalid", 32'(rvalid_o), 32'd2);
    check_eq("raw.rd.rdata",  rd(1),         32'h1234_5678);
    check_eq("raw.rd.err",    32'(err_o[1]), 32'd0);
    // Port 0's held data must not change on port 1's response.
    check_eq("raw.hold0",     rd(0),         32'h0);

    // Out-of-range read and write at byte address NUM_BYTES.
    access("oor.rd", 0, 1'b0, 16'h0400, 4'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    access("oor.wr", 1, 1'b1, 16'h0400, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);
    access("oor.w00", 0, 1'b0, 16'h0000, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
    access("oor.w10", 1, 1'b0, 16'h0010, 4'h0, 32'h0, 1'b1, 32'h00BB_00DD, 1'b0);
    access("oor.w20", 0, 1'b0, 16'h0020, 4'h0, 32'h0, 1'b1, 32'h1234_5678, 1'b0);

    // Reset right after a granted read, with a write pending at the reset edge.
    drive(1, 1'b0, 16'h0020, 4'h0, 32'h0);
    #1;
    @(posedge clk); #1;
    check_eq("mid.pre.rvalid", 32'(rvalid_o), 32'd2);
    req_i  = '0;
    rstn_i = 1'b0;
    drive(0, 1'b1, 16'h0010, 4'hF, 32'hFFFF_FFFF);
    #1;
    check_eq("mid.rvalid", 32'(rvalid_o), 32'd0);
    check_eq("mid.rdata0", rd(0), 32'h0000_0013);
    check_eq("mid.rdata1", rd(1), 32'h0000_0013);
    @(posedge clk); #1;
    check_eq("mid.edge.rvalid", 32'(rvalid_o), 32'd0);
    check_eq("mid.edge.err",    32'(err_o),    32'd0);
    req_i = '0;
    @(posedge clk); #1;
    rstn_i = 1'b1;

    // After reset the pointer is back at port 0; contents are retained.
    drive(0, 1'b0, 16'h0010, 4'h0, 32'h0);
    drive(1, 1'b0, 16'h0020, 4'h0, 32'h0);
    #1;
    check_eq("post.gnt", 32'(gnt_o), 32'd1);
    @(posedge clk); #1;
    req_i = '0;
    check_eq("post.rd10", rd(0), 32'h00BB_00DD);
    access("post.rd20", 1, 1'b0, 16'h0020, 4'h0, 32'h0, 1'b1, 32'h1234_5678, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
